// File: rtl/ariane_axi.sv
// ariane_axi: AXI request/response bundle types used by the NoC throttle.
// The request carries AW/W/AR payloads plus their valids and the B/R
// ready signals. The response carries the AW/W/AR readies plus the B/R
// payloads and their valids.
package ariane_axi;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
   } ax_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;

endpackage

// File: rtl/ariane_axi_pkg.sv
// ariane_axi_pkg: shared types for the AXI outstanding-transaction throttle.
//   ariane_axi_throttle_state_e : per-channel issue FSM state
//     OPEN    - new address requests may be issued, subject to gating
//     PENDING - an address request was offered and not yet accepted; it is
//               held ungated until the handshake completes
package ariane_axi_pkg;

   typedef enum logic {
      OPEN    = 1'b0,
      PENDING = 1'b1
   } ariane_axi_throttle_state_e;

   localparam int unsigned CntOutW = 8;

endpackage

// File: rtl/ariane_axi_throttle_chan.sv
// ariane_axi_throttle_chan: one address channel (AR or AW) of the throttle.
// It counts outstanding transactions and gates new address issue while
// draining or while the count is at Max.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   drain              block new issue while high
//   up_valid/up_ready  address handshake on the core side
//   dn_valid/dn_ready  address handshake on the interconnect side
//   dec                completion handshake (R with last, or B)
//   cnt                outstanding count, zero-extended to 8 bits
//   state              FSM state (OPEN/PENDING)
//   err                sticky: completion seen while count was zero
module ariane_axi_throttle_chan
   import ariane_axi_pkg::*;
#(
   parameter int unsigned Max = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       drain,
   input  logic                       up_valid,
   output logic                       up_ready,
   output logic                       dn_valid,
   input  logic                       dn_ready,
   input  logic                       dec,
   output logic [CntOutW-1:0]         cnt,
   output ariane_axi_throttle_state_e state,
   output logic                       err
);

   localparam int unsigned CntW = $clog2(Max + 1);

   ariane_axi_throttle_state_e state_q, state_d;
   logic [CntW-1:0]            cnt_q;
   logic                       err_q;
   logic                       block;
   logic                       inc;

   // Block uses only the registered count and drain, so a response never
   // reaches the downstream valid combinationally.
   assign block = drain || (cnt_q == CntW'(Max));
   assign inc   = dn_valid && dn_ready;

   always_comb begin
      state_d  = state_q;
      dn_valid = 1'b0;
      up_ready = 1'b0;
      unique case (state_q)
         OPEN: begin
            dn_valid = up_valid && !block;
            up_ready = dn_ready && !block;
            if (dn_valid && !dn_ready) state_d = PENDING;
         end
         PENDING: begin
            // An offered request must stay valid until accepted.
            dn_valid = up_valid;
            up_ready = dn_ready;
            if (dn_valid && dn_ready) state_d = OPEN;
         end
         default: state_d = OPEN;
      endcase
   end

   // Entry into PENDING requires count < Max, and leaving PENDING is the
   // only increment that can happen there, so the count cannot pass Max.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= OPEN;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (inc && !dec) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (dec && !inc) begin
            if (cnt_q == '0) err_q <= 1'b1;
            else             cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

   assign cnt   = CntOutW'(cnt_q);
   assign state = state_q;
   assign err   = err_q;

endmodule

// File: rtl/ariane_axi_throttle.sv
// ariane_axi_throttle: limits outstanding AXI read and write transactions
// between a core and the interconnect. Every field passes through with
// zero latency, except the AR/AW valid/ready pairs, which are gated.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   drain_i                block new AR/AW issue while high
//   core_req_i/core_resp_o core-side AXI bundle
//   noc_req_o/noc_resp_i   interconnect-side AXI bundle
//   rd_cnt_o, wr_cnt_o     outstanding read/write counts
//   idle_o                 counts zero and neither channel PENDING
//   err_o                  sticky: response received with count zero
module ariane_axi_throttle
   import ariane_axi_pkg::*;
#(
   parameter int unsigned MaxReadTxns  = 4,
   parameter int unsigned MaxWriteTxns = 4,
   parameter type noc_req_t  = ariane_axi::req_t,
   parameter type noc_resp_t = ariane_axi::resp_t
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        drain_i,
   input  noc_req_t    core_req_i,
   output noc_resp_t   core_resp_o,
   output noc_req_t    noc_req_o,
   input  noc_resp_t   noc_resp_i,
   output logic [7:0]  rd_cnt_o,
   output logic [7:0]  wr_cnt_o,
   output logic        idle_o,
   output logic        err_o
);

   logic                       ar_valid, ar_ready, aw_valid, aw_ready;
   logic                       rd_dec, wr_dec;
   logic                       rd_err, wr_err;
   ariane_axi_throttle_state_e rd_state, wr_state;

   assign rd_dec = noc_resp_i.r_valid && core_req_i.r_ready && noc_resp_i.r.last;
   assign wr_dec = noc_resp_i.b_valid && core_req_i.b_ready;

   ariane_axi_throttle_chan #(
      .Max (MaxReadTxns)
   ) i_rd_chan (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .drain    (drain_i),
      .up_valid (core_req_i.ar_valid),
      .up_ready (ar_ready),
      .dn_valid (ar_valid),
      .dn_ready (noc_resp_i.ar_ready),
      .dec      (rd_dec),
      .cnt      (rd_cnt_o),
      .state    (rd_state),
      .err      (rd_err)
   );

   ariane_axi_throttle_chan #(
      .Max (MaxWriteTxns)
   ) i_wr_chan (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .drain    (drain_i),
      .up_valid (core_req_i.aw_valid),
      .up_ready (aw_ready),
      .dn_valid (aw_valid),
      .dn_ready (noc_resp_i.aw_ready),
      .dec      (wr_dec),
      .cnt      (wr_cnt_o),
      .state    (wr_state),
      .err      (wr_err)
   );

   always_comb begin
      noc_req_o          = core_req_i;
      noc_req_o.ar_valid = ar_valid;
      noc_req_o.aw_valid = aw_valid;
   end

   always_comb begin
      core_resp_o          = noc_resp_i;
      core_resp_o.ar_ready = ar_ready;
      core_resp_o.aw_ready = aw_ready;
   end

   assign idle_o = (rd_cnt_o == '0) && (wr_cnt_o == '0) &&
                   (rd_state == OPEN) && (wr_state == OPEN);
   assign err_o  = rd_err || wr_err;

endmodule

// File: doc/ariane_axi_throttle.md
ARIANE_AXI_THROTTLE -- requirements
Module: ariane_axi_throttle

Interface
REQ-001 SHALL have parameter MaxReadTxns, default 4, maximum outstanding AR transactions (legal range 1..255).
REQ-002 SHALL have parameter MaxWriteTxns, default 4, maximum outstanding AW transactions (legal range 1..255).
REQ-003 SHALL have parameters noc_req_t, default ariane_axi::req_t, and noc_resp_t, default ariane_axi::resp_t, the AXI request/response bundle types.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port drain_i  input  1  block new AR/AW issue while high.
REQ-007 SHALL have port core_req_i  input  noc_req_t  request from the core's noc_req_o.
REQ-008 SHALL have port core_resp_o  output  noc_resp_t  response to the core.
REQ-009 SHALL have port noc_req_o  output  noc_req_t  request to the interconnect.
REQ-010 SHALL have port noc_resp_i  input  noc_resp_t  response from the interconnect.
REQ-011 SHALL have ports rd_cnt_o / wr_cnt_o  output  8 each  current outstanding read/write counts.
REQ-012 SHALL have port idle_o  output  1  both counts zero and no AR/AW pending.
REQ-013 SHALL have port err_o  output  1  sticky: response received with count zero.

Function
REQ-014 All fields other than ar_valid, aw_valid, ar_ready and aw_ready SHALL pass through combinationally, zero latency.
REQ-015 Per channel (AR, AW), an FSM SHALL have states OPEN and PENDING.
REQ-016 OPEN: block = drain_i or count == Max; downstream valid = upstream valid and not block; upstream ready = downstream ready and not block.
REQ-017 OPEN -> PENDING when downstream valid is high and downstream ready is low.
REQ-018 PENDING: valid and ready SHALL pass through ungated regardless of drain_i or count (AXI valid-stability); PENDING -> OPEN on handshake.
REQ-019 Block SHALL depend only on registered count and drain_i; there SHALL be no combinational path from noc_resp_i valid/last to noc_req_o valid.
REQ-020 Read count SHALL increment on AR handshake and decrement on R handshake with r.last.
REQ-021 Write count SHALL increment on AW handshake and decrement on B handshake.
REQ-022 A simultaneous increment and decrement in the same cycle SHALL leave the count unchanged.
REQ-023 A decrement with count zero SHALL leave count at 0 and set err_o, which holds until reset.
REQ-024 Count SHALL never exceed Max; a count equal to Max blocks issue in the same cycle.
REQ-025 W, R and B channels SHALL never be gated.
REQ-026 idle_o SHALL be combinational from the registered counts and FSM states.

Reset
REQ-027 With rst_ni low at a clock edge: counts = 0, both FSMs = OPEN, err_o = 0.
REQ-028 With rst_ni low: idle_o = 1, rd_cnt_o = wr_cnt_o = 0; passthrough outputs follow their inputs per REQ-014/016.
REQ-029 Reset asserted mid-transaction SHALL discard all outstanding state without error; the system resets interconnect and core together.

Structure
REQ-030 Type ariane_axi_throttle_state_e {OPEN, PENDING} SHALL reside in ariane_axi_pkg.
REQ-031 Sub-module ariane_axi_throttle_chan SHALL hold one FSM, one counter and the gating, parameterised by Max, and SHALL be instantiated twice (read, write).
REQ-032 Counter width SHALL be $clog2(Max+1), zero-extended to 8 bits on the output.

Verification
REQ-033 MaxReadTxns=2; issue 3 ARs with ready high and no R -> 2 accepted, third ar_ready low, rd_cnt_o=2; one R with last -> third accepted next cycle, rd_cnt_o=2.
REQ-034 AR valid with downstream ready low, then drain_i=1 -> noc ar_valid stays high until handshake, rd_cnt_o=1; a following AR stays blocked while drain_i=1.
REQ-035 wr_cnt_o=1; AW handshake and B handshake in the same cycle -> wr_cnt_o remains 1, err_o=0.
REQ-036 B handshake with wr_cnt_o=0 -> err_o=1 and stays 1; wr_cnt_o=0; reset clears err_o.
REQ-037 3 ARs outstanding, then a multi-beat R with last only on beat 4 -> rd_cnt_o decrements once, after beat 4; idle_o=1 only after all counts reach 0.
REQ-038 Reset pulsed with rd_cnt_o=2 and AW PENDING -> next cycle counts 0, idle_o=1, aw_valid follows the core ungated.
